// File: rtl/echo_capture.sv
// echo_capture: frame-gated ADC capture with blanking, decimation and an
// AXI-Stream output FIFO whose last word sits in a registered output stage.
module echo_capture #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_sync,
    input  logic [15:0]       blank_len,
    input  logic [15:0]       frame_len,
    input  logic [7:0]        decim,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_CAPTURE
    } state_t;

    state_t            r_state;
    logic              r_fs_q;
    logic [15:0]       r_blank_cnt;
    logic [15:0]       r_idx;
    logic [7:0]        r_dec_cnt;
    logic              r_done;
    logic              r_ovf;

    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    // Occupancy counts the memory plus the output register.
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic w_start;
    logic w_keep;
    logic w_last;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_mem_avail;
    logic w_load;

    assign w_start     = frame_sync & ~r_fs_q & enable;
    assign w_keep      = (r_state == S_CAPTURE) & enable & adc_valid &
                         (r_dec_cnt == 8'd0) & (frame_len != 16'd0);
    assign w_last      = (r_idx == frame_len - 16'd1);
    assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
    assign w_push      = w_keep & ~w_full;
    assign w_drop      = w_keep & w_full;
    assign w_pop       = r_out_valid & m_axis_tready;
    assign w_mem_avail = (r_cnt > CW'(r_out_valid));
    assign w_load      = w_mem_avail & (~r_out_valid | m_axis_tready);

    // Frame sequencing: start detection, blanking, decimation and indexing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fs_q      <= 1'b1;
            r_blank_cnt <= '0;
            r_idx       <= '0;
            r_dec_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_fs_q <= frame_sync;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_blank_cnt <= '0;
                        r_dec_cnt   <= '0;
                        r_idx       <= '0;
                        r_state     <= (blank_len == 16'd0) ? S_CAPTURE : S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (adc_valid) begin
                        if (r_blank_cnt + 16'd1 == blank_len) begin
                            r_state   <= S_CAPTURE;
                            r_dec_cnt <= '0;
                            r_idx     <= '0;
                        end else begin
                            r_blank_cnt <= r_blank_cnt + 16'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (frame_len == 16'd0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (adc_valid) begin
                        r_dec_cnt <= (r_dec_cnt == decim) ? 8'd0 : r_dec_cnt + 8'd1;
                        // A dropped sample still consumes its index and can end the frame.
                        if (w_keep) begin
                            r_idx <= r_idx + 16'd1;
                            if (w_last) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow flag, cleared when capture is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!enable) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // FIFO storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, adc_data};
        end
    end

    // FIFO pointers, occupancy and the registered stream output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[r_rd_ptr][DATA_W-1:0];
                r_out_last  <= r_mem[r_rd_ptr][DATA_W];
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = r_done;
    assign overflow      = r_ovf;

endmodule
